// File: rtl/tone_scheduler.sv
// Fixed-priority arbiter that lends one square-wave tone generator to NUM_REQ note
// requesters, with a minimum hold per note and a silent gap between notes.
module tone_scheduler #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned PERIOD_W   = 16,
   parameter int unsigned MIN_HOLD   = 256,
   parameter int unsigned GAP_CYCLES = 64
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*PERIOD_W-1:0] period_in,
   output logic [NUM_REQ-1:0]          grant,
   output logic                        active,
   output logic                        speaker
);

   localparam int unsigned HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
   localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

   state_t              r_state,    w_state_nxt;
   logic [NUM_REQ-1:0]  r_grant,    w_grant_nxt;
   logic                r_active,   w_active_nxt;
   logic                r_speaker,  w_speaker_nxt;
   logic [PERIOD_W-1:0] r_period,   w_period_nxt;
   logic [PERIOD_W-1:0] r_tone_cnt, w_tone_nxt;
   logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;
   logic [GAP_W-1:0]    r_gap_cnt,  w_gap_nxt;

   logic [NUM_REQ-1:0]  w_sel_grant;
   logic [PERIOD_W-1:0] w_sel_period;
   logic [PERIOD_W-1:0] w_sel_p;
   logic                w_found;
   logic                w_owner_req;
   logic                w_lower_req;
   logic                w_release;

   // Lowest set request index wins; its half-period is clamped to at least 2.
   always_comb begin
      w_sel_grant  = '0;
      w_sel_period = '0;
      w_found      = 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (req[i] && !w_found) begin
            w_found        = 1'b1;
            w_sel_grant[i] = 1'b1;
            w_sel_period   = period_in[i*PERIOD_W +: PERIOD_W];
         end
      end
      w_sel_p = (w_sel_period < PERIOD_W'(2)) ? PERIOD_W'(2) : w_sel_period;
   end

   // grant-1 of a one-hot owner masks exactly the higher-priority requesters.
   assign w_owner_req = |(req & r_grant);
   assign w_lower_req = |(req & (r_grant - NUM_REQ'(1)));
   assign w_release   = (r_hold_cnt == '0) && (!w_owner_req || w_lower_req);

   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_active_nxt  = r_active;
      w_speaker_nxt = r_speaker;
      w_period_nxt  = r_period;
      w_tone_nxt    = r_tone_cnt;
      w_hold_nxt    = r_hold_cnt;
      w_gap_nxt     = r_gap_cnt;
      if (!enable) begin
         w_state_nxt   = S_IDLE;
         w_grant_nxt   = '0;
         w_active_nxt  = 1'b0;
         w_speaker_nxt = 1'b0;
         w_period_nxt  = '0;
         w_tone_nxt    = '0;
         w_hold_nxt    = '0;
         w_gap_nxt     = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|req) begin
                  w_state_nxt   = S_PLAY;
                  w_grant_nxt   = w_sel_grant;
                  w_active_nxt  = 1'b1;
                  w_speaker_nxt = 1'b0;
                  w_period_nxt  = w_sel_p;
                  w_tone_nxt    = w_sel_p - PERIOD_W'(1);
                  w_hold_nxt    = HOLD_W'(MIN_HOLD - 1);
               end
            end
            S_PLAY: begin
               if (w_release) begin
                  w_state_nxt   = S_GAP;
                  w_grant_nxt   = '0;
                  w_active_nxt  = 1'b0;
                  w_speaker_nxt = 1'b0;
                  w_tone_nxt    = '0;
                  w_gap_nxt     = GAP_W'(GAP_CYCLES - 1);
               end else begin
                  if (r_tone_cnt == '0) begin
                     w_speaker_nxt = ~r_speaker;
                     w_tone_nxt    = r_period - PERIOD_W'(1);
                  end else begin
                     w_tone_nxt = r_tone_cnt - PERIOD_W'(1);
                  end
                  if (r_hold_cnt != '0) begin
                     w_hold_nxt = r_hold_cnt - HOLD_W'(1);
                  end
               end
            end
            S_GAP: begin
               w_speaker_nxt = 1'b0;
               if (r_gap_cnt == '0) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_gap_nxt = r_gap_cnt - GAP_W'(1);
               end
            end
            default: begin
               w_state_nxt   = S_IDLE;
               w_grant_nxt   = '0;
               w_active_nxt  = 1'b0;
               w_speaker_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_grant    <= '0;
         r_active   <= 1'b0;
         r_speaker  <= 1'b0;
         r_period   <= '0;
         r_tone_cnt <= '0;
         r_hold_cnt <= '0;
         r_gap_cnt  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_active   <= w_active_nxt;
         r_speaker  <= w_speaker_nxt;
         r_period   <= w_period_nxt;
         r_tone_cnt <= w_tone_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_gap_cnt  <= w_gap_nxt;
      end
   end

   assign grant   = r_grant;
   assign active  = r_active;
   assign speaker = r_speaker;

endmodule

// File: tb/tb_tone_scheduler.sv
// Directed bench for tone_scheduler: a table of per-cycle vectors plus hand-written
// sequences for async reset and half-period clamping.
module tb_tone_scheduler;

   localparam int unsigned NUM_REQ  = 4;
   localparam int unsigned PERIOD_W = 16;

   typedef struct {
      logic       en;
      logic [3:0] req;
      int         ncyc;
      logic [3:0] g;
      logic       a;
      logic       s;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [3:0]  req;
   logic [63:0] period_in;
   logic [3:0]  grant;
   logic        active;
   logic        speaker;

   int n_checks;
   int n_errors;
   vec_t tbl[$];

   tone_scheduler #(
      .NUM_REQ    (NUM_REQ),
      .PERIOD_W   (PERIOD_W),
      .MIN_HOLD   (8),
      .GAP_CYCLES (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .req       (req),
      .period_in (period_in),
      .grant     (grant),
      .active    (active),
      .speaker   (speaker)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [3:0] g, input logic a, input logic s);
      check({tag, " grant"},   32'(grant),   32'(g));
      check({tag, " active"},  32'(active),  32'(a));
      check({tag, " speaker"}, 32'(speaker), 32'(s));
   endtask

   task automatic add(input logic en, input logic [3:0] r, input int n,
                      input logic [3:0] g, input logic a, input logic s);
      vec_t v;
      v.en = en; v.req = r; v.ncyc = n; v.g = g; v.a = a; v.s = s;
      tbl.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b1;
      enable    = 1'b0;
      req       = 4'b0000;
      period_in = {16'd8, 16'd7, 16'd6, 16'd5};

      // req2 alone: P=7, rise 7 cycles after entry, period 14
      add(1, 4'b0100, 1, 4'b0100, 1, 0);
      add(1, 4'b0100, 6, 4'b0100, 1, 0);
      add(1, 4'b0100, 1, 4'b0100, 1, 1);
      add(1, 4'b0100, 6, 4'b0100, 1, 1);
      add(1, 4'b0100, 1, 4'b0100, 1, 0);
      add(1, 4'b0100, 7, 4'b0100, 1, 1);
      add(0, 4'b0000, 1, 4'b0000, 0, 0);
      // req3 pulsed 2 cycles: 8 PLAY cycles, 4 GAP, IDLE, then regrant
      add(1, 4'b1000, 1, 4'b1000, 1, 0);
      add(1, 4'b0000, 1, 4'b1000, 1, 0);
      add(1, 4'b0000, 6, 4'b1000, 1, 0);
      add(1, 4'b0000, 1, 4'b0000, 0, 0);
      add(1, 4'b0000, 3, 4'b0000, 0, 0);
      add(1, 4'b1000, 1, 4'b0000, 0, 0);
      add(1, 4'b1000, 1, 4'b1000, 1, 0);
      add(0, 4'b0000, 1, 4'b0000, 0, 0);
      // req0+req1 together: req0 wins, period 10; req1 after req0 drops
      add(1, 4'b0011, 1, 4'b0001, 1, 0);
      add(1, 4'b0011, 4, 4'b0001, 1, 0);
      add(1, 4'b0011, 1, 4'b0001, 1, 1);
      add(1, 4'b0011, 5, 4'b0001, 1, 0);
      add(1, 4'b0011, 2, 4'b0001, 1, 0);
      add(1, 4'b0010, 1, 4'b0000, 0, 0);
      add(1, 4'b0010, 4, 4'b0000, 0, 0);
      add(1, 4'b0010, 1, 4'b0010, 1, 0);
      add(0, 4'b0000, 1, 4'b0000, 0, 0);
      // req3 playing, req0 arrives at cycle 3: preempted only at cycle 8
      add(1, 4'b1000, 1, 4'b1000, 1, 0);
      add(1, 4'b1000, 2, 4'b1000, 1, 0);
      add(1, 4'b1001, 1, 4'b1000, 1, 0);
      add(1, 4'b1001, 4, 4'b1000, 1, 0);
      add(1, 4'b1001, 1, 4'b0000, 0, 0);
      add(1, 4'b1001, 4, 4'b0000, 0, 0);
      add(1, 4'b1001, 1, 4'b0001, 1, 0);
      // enable dropped mid-PLAY: immediate IDLE, regrant 1 cycle after re-enable
      add(0, 4'b1001, 1, 4'b0000, 0, 0);
      add(0, 4'b1001, 2, 4'b0000, 0, 0);
      add(1, 4'b1001, 1, 4'b0001, 1, 0);

      repeat (2) tick();
      check_out("reset", 4'b0000, 1'b0, 1'b0);
      reset  = 1'b0;
      enable = 1'b1;
      tick();
      check_out("idle", 4'b0000, 1'b0, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         enable = tbl[i].en;
         req    = tbl[i].req;
         repeat (tbl[i].ncyc) tick();
         check_out($sformatf("row%0d", i), tbl[i].g, tbl[i].a, tbl[i].s);
      end

      // Half-period below 2 is clamped; period_in changes during PLAY are ignored
      enable = 1'b0;
      req    = 4'b0000;
      tick();
      period_in = {16'd8, 16'd7, 16'd6, 16'd1};
      enable    = 1'b1;
      req       = 4'b0001;
      tick();
      check_out("clamp e0", 4'b0001, 1'b1, 1'b0);
      tick();
      check("clamp e1 speaker", 32'(speaker), 32'd0);
      tick();
      check("clamp e2 speaker", 32'(speaker), 32'd1);
      period_in = {16'd8, 16'd7, 16'd6, 16'd9};
      tick();
      check("clamp e3 speaker", 32'(speaker), 32'd1);
      tick();
      check("clamp e4 speaker", 32'(speaker), 32'd0);
      repeat (2) tick();
      check("clamp e6 speaker", 32'(speaker), 32'd1);

      // Async reset during PLAY with speaker high, then regrant via IDLE
      enable = 1'b0;
      req    = 4'b0000;
      tick();
      period_in = {16'd8, 16'd7, 16'd6, 16'd5};
      enable    = 1'b1;
      req       = 4'b0010;
      tick();
      check_out("rst e0", 4'b0010, 1'b1, 1'b0);
      repeat (5) tick();
      check("rst e5 speaker", 32'(speaker), 32'd0);
      tick();
      check_out("rst e6", 4'b0010, 1'b1, 1'b1);
      #2 reset = 1'b1;
      #1 check_out("rst async", 4'b0000, 1'b0, 1'b0);
      #2 reset = 1'b0;
      tick();
      check_out("rst regrant", 4'b0010, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
